imem_program_loader: RTL and testbench
======================================

// Module: imem_program_loader
// PURPOSE
//  Loads a program into Instruction_Memory before execution. Receives a framed byte stream
//  (count header, little-endian words, XOR checksum) over a valid/ready handshake and packs it
//  into 32-bit words. Drives the instruction-memory write port and holds the CPU in reset until
//  a load completes cleanly. Sits directly upstream of Instruction_Memory and Program_Counter.
// PARAMETERS
//  DEPTH   64  instruction words in Instruction_Memory; a legal load has 1..DEPTH words
//  ADDR_W  6   word-address width, $clog2(DEPTH); matches read_address[7:2] indexing
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst         in   1       synchronous, active-low reset (rst==0 at posedge clk resets)
//  load_start  in   1       one-cycle pulse; begins a load (see BEHAVIOUR)
//  byte_valid  in   1       byte_data is valid
//  byte_data   in   8       stream byte
//  byte_ready  out  1       loader accepts byte this cycle; transfer = byte_valid & byte_ready
//  imem_we     out  1       one-cycle instruction-memory write strobe
//  imem_addr   out  ADDR_W  word address for the write
//  imem_wdata  out  32      assembled instruction word
//  cpu_hold    out  1       1 = keep CPU (PC, register file) in reset
//  load_done   out  1       one-cycle pulse: load and checksum succeeded
//  load_error  out  1       sticky: bad count or checksum mismatch
// BEHAVIOUR
//  Reset (rst==0): state=IDLE; byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0,
//   load_done=0, load_error=0, cpu_hold=1. The "loaded" flag clears. Applies in any state,
//   including mid-load. Words already written stay in memory.
//  Frame: header byte N, then 4*N data bytes (byte0 = instr[7:0] .. byte3 = instr[31:24]),
//   then a checksum byte equal to the XOR of N and all data bytes.
//  All outputs are registered. byte_ready=1 only in HEADER, DATA and CHECK.
//  FSM:
//   IDLE:   load_start -> HEADER; clear load_error, XOR accumulator, word index and byte counter.
//   HEADER: on transfer, latch N and XOR it into the accumulator.
//           N==0 or N>DEPTH -> ERROR; otherwise -> DATA.
//   DATA:   on each transfer, shift the byte into position byte_cnt and XOR it in.
//           On the 4th byte -> WRITE.
//   WRITE:  byte_ready=0. imem_we=1 for exactly one cycle, imem_addr=word index,
//           imem_wdata=assembled word. Increment word index and zero byte_cnt.
//           If index was N-1 -> CHECK, else -> DATA.
//   CHECK:  on transfer, byte==accumulator -> DONE, else -> ERROR.
//   DONE:   load_done=1 for one cycle; set loaded=1; -> IDLE.
//   ERROR:  load_error=1 and held; cpu_hold=1. load_start -> HEADER, which clears load_error.
//  cpu_hold = 1 unless (state==IDLE and loaded==1).
//   It drops the cycle after load_done, i.e. when the FSM is back in IDLE.
//  load_start in HEADER, DATA, WRITE, CHECK or DONE is ignored; it does not restart the load.
//  loaded clears when a new load starts, so cpu_hold rises for a reload.
//  Latency: the word write occurs 1 cycle after its 4th byte transfers.
//   Minimum load time is 4 + 5N cycles (start, header, 4N bytes, N writes, checksum, done).
//  byte_valid gaps: the FSM waits with no timeout.
//   A byte offered in WRITE/IDLE/DONE/ERROR is not consumed and must be held by the source.
//  Word index never exceeds N-1 <= DEPTH-1, so imem_addr never wraps.
//  imem_wdata and imem_addr hold their last values when imem_we=0.
// TESTING
//  T1: rst=0 for 2 cycles -> cpu_hold=1, all other outputs 0.
//   Then start; stream 01,83,20,00,00,A2 -> one imem_we, addr 0, wdata 32'h00002083;
//   load_done pulses; cpu_hold=0 next cycle.
//  T2: as T1 but checksum 00 -> no load_done, load_error=1 and held, cpu_hold=1.
//   Then start plus a valid frame -> load_error clears, load succeeds.
//  T3: header 00, then header 41 (65) -> ERROR right after header, no imem_we, load_error=1.
//  T4: N=40 (64 words), word k = 32'h1000_0000+k, correct checksum -> 64 writes, addr 0..63
//   in order, data matches, load_done once.
//  T5: byte_valid held high with random gaps -> byte_ready=0 during every WRITE cycle,
//   no byte lost or duplicated; load_start pulsed mid-DATA is ignored.
//  T6: rst=0 after 2 of 3 words -> reset values next cycle; a fresh full load then succeeds.

Source files
------------

// File: rtl/imem_program_loader_if.sv
// Byte-stream and instruction-memory write bundle for the program loader.
// The slave modport is the loader side; the master modport is the host/memory side.
interface imem_program_loader_if #(
  parameter int ADDR_W = 6
);
  logic              load_start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;

  modport master (
    output load_start, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error
  );

  modport slave (
    input  load_start, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/imem_program_loader.sv
// Packs a framed byte stream (count, LE words, XOR checksum) into instruction-memory writes.
// Holds the CPU in reset until a load completes cleanly; one write cycle per word.
module imem_program_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_program_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, HEADER, DATA, WRITE, CHECK, DONE, ERROR
  } state_t;

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_t      state, state_nxt;
  logic [7:0]  n_words;
  logic [7:0]  acc;
  logic [7:0]  word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] word_lo;
  logic        loaded, loaded_nxt;
  logic        start_load;
  logic        xfer;

  assign xfer = bus.byte_valid & bus.byte_ready;

  always_comb begin
    state_nxt  = state;
    loaded_nxt = loaded;
    start_load = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load_start) begin
          state_nxt  = HEADER;
          start_load = 1'b1;
        end
      end
      HEADER: begin
        if (xfer) begin
          if (bus.byte_data == 8'd0 || bus.byte_data > DEPTH_B) state_nxt = ERROR;
          else                                                   state_nxt = DATA;
        end
      end
      DATA: begin
        if (xfer && byte_cnt == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = (word_idx == n_words - 8'd1) ? CHECK : DATA;
      end
      CHECK: begin
        if (xfer) state_nxt = (bus.byte_data == acc) ? DONE : ERROR;
      end
      DONE: begin
        state_nxt  = IDLE;
        loaded_nxt = 1'b1;
      end
      ERROR: begin
        if (bus.load_start) begin
          state_nxt  = HEADER;
          start_load = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A new load always re-asserts the CPU hold.
    if (start_load) loaded_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      loaded         <= 1'b0;
      n_words        <= 8'd0;
      acc            <= 8'd0;
      word_idx       <= 8'd0;
      byte_cnt       <= 2'd0;
      word_lo        <= 24'd0;
      bus.byte_ready <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'd0;
      bus.cpu_hold   <= 1'b1;
      bus.load_done  <= 1'b0;
      bus.load_error <= 1'b0;
    end else begin
      state  <= state_nxt;
      loaded <= loaded_nxt;

      // Outputs are decoded from the next state so they line up with the registered state.
      bus.byte_ready <= (state_nxt == HEADER) || (state_nxt == DATA) || (state_nxt == CHECK);
      bus.imem_we    <= (state_nxt == WRITE);
      bus.load_done  <= (state_nxt == DONE);
      bus.cpu_hold   <= !((state_nxt == IDLE) && loaded_nxt);

      if (start_load) begin
        bus.load_error <= 1'b0;
        acc            <= 8'd0;
        word_idx       <= 8'd0;
        byte_cnt       <= 2'd0;
      end else if (state_nxt == ERROR) begin
        bus.load_error <= 1'b1;
      end

      if (state == HEADER && xfer) begin
        n_words <= bus.byte_data;
        acc     <= acc ^ bus.byte_data;
      end

      if (state == DATA && xfer) begin
        acc      <= acc ^ bus.byte_data;
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: word_lo[7:0]   <= bus.byte_data;
          2'd1: word_lo[15:8]  <= bus.byte_data;
          2'd2: word_lo[23:16] <= bus.byte_data;
          default: begin
            bus.imem_addr  <= word_idx[ADDR_W-1:0];
            bus.imem_wdata <= {bus.byte_data, word_lo};
          end
        endcase
      end

      if (state == WRITE) begin
        word_idx <= word_idx + 8'd1;
        byte_cnt <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench: frames are built from word lists, expected writes are queued per word
// and a negedge scoreboard checks every write, the write/ready exclusion and load_done.
module tb_imem_program_loader;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_program_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [31:0] last_wdata = 32'd0;
  logic [7:0]  frame_ck = 8'd0;
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       exp_data_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every write must match the next queued word.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.imem_we) begin
        wr_cnt++;
        last_wdata = bus.imem_wdata;
        check("ready_low_during_write", 32'(bus.byte_ready), 32'd0);
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %h, no write expected", bus.imem_addr, bus.imem_wdata);
        end else begin
          check("write_addr", 32'(bus.imem_addr), 32'(exp_addr_q.pop_front()));
          check("write_data", bus.imem_wdata, exp_data_q.pop_front());
        end
      end
      if (bus.load_done) begin
        done_cnt++;
        check("hold_during_done", 32'(bus.cpu_hold), 32'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps && $urandom_range(0, 2) == 0) begin
      bus.byte_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.byte_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL byte_accept_timeout: byte %h not accepted in 100 cycles", b);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
  endtask

  task automatic send_word(input int k, input logic [31:0] w, input bit gaps, input bit mid_start);
    logic [31:0] wv;
    wv = w;
    exp_addr_q.push_back(ADDR_W'(k));
    exp_data_q.push_back(wv);
    for (int b = 0; b < 4; b++) begin
      if (mid_start && b == 1) begin
        bus.byte_valid = 1'b0;
        pulse_start();
      end
      send_byte(wv[8*b +: 8], gaps);
      frame_ck = frame_ck ^ wv[8*b +: 8];
    end
  endtask

  // ck_force < 0 sends the correct checksum, otherwise sends ck_force.
  task automatic send_frame(input int n, input logic [31:0] base, input int ck_force,
                            input bit gaps, input bit mid_start);
    frame_ck = 8'(n);
    send_byte(8'(n), gaps);
    for (int k = 0; k < n; k++) send_word(k, base + 32'(k), gaps, mid_start && k == 1);
    send_byte((ck_force < 0) ? frame_ck : 8'(ck_force), gaps);
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_outcome(output bit done, output bit err);
    done = 1'b0;
    err  = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.load_done)  begin done = 1'b1; return; end
      if (bus.load_error) begin err  = 1'b1; return; end
    end
    checks++;
    errors++;
    $display("FAIL outcome_timeout: neither load_done nor load_error in 2000 cycles");
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_hold"},   32'(bus.cpu_hold),   32'd1);
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
    check({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
    check({tag, "_imem_wdata"}, bus.imem_wdata,      32'd0);
    check({tag, "_load_done"},  32'(bus.load_done),  32'd0);
    check({tag, "_load_error"}, 32'(bus.load_error), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit d, e;
    int base_done, base_wr;
    bus.load_start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("t1_reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: single-word load, minimum latency 4+5N ends with the done cycle.
    pulse_start();
    send_frame(1, 32'h0000_2083, -1, 1'b0, 1'b0);
    check("t1_checksum_model", 32'(frame_ck), 32'h0000_00A2);
    wait_outcome(d, e);
    check("t1_done", 32'(d), 32'd1);
    check("t1_latency", 32'(cyc - start_cyc), 32'(5 * 1 + 3));
    @(negedge clk);
    check("t1_hold_dropped", 32'(bus.cpu_hold), 32'd0);
    check("t1_done_one_cycle", 32'(bus.load_done), 32'd0);
    check("t1_wdata_literal", last_wdata, 32'h0000_2083);
    check("t1_write_count", 32'(wr_cnt), 32'd1);
    @(posedge clk);
    #1;

    // T2: wrong checksum is sticky until the next start; a good frame then recovers.
    base_done = done_cnt;
    pulse_start();
    send_frame(1, 32'h0000_2083, 0, 1'b0, 1'b0);
    wait_outcome(d, e);
    check("t2_error_seen", 32'(e), 32'd1);
    repeat (5) @(negedge clk);
    check("t2_error_held", 32'(bus.load_error), 32'd1);
    check("t2_hold_high", 32'(bus.cpu_hold), 32'd1);
    check("t2_no_done", 32'(done_cnt - base_done), 32'd0);
    @(posedge clk);
    #1;
    pulse_start();
    check("t2_error_cleared", 32'(bus.load_error), 32'd0);
    send_frame(2, 32'hCAFE_0000, -1, 1'b0, 1'b0);
    wait_outcome(d, e);
    check("t2_recover_done", 32'(d), 32'd1);
    @(posedge clk);
    #1;

    // T3: illegal counts fail immediately after the header, with no writes.
    base_wr = wr_cnt;
    pulse_start();
    check("t3_hold_on_reload", 32'(bus.cpu_hold), 32'd1);
    send_byte(8'h00, 1'b0);
    bus.byte_valid = 1'b0;
    check("t3_zero_count_error", 32'(bus.load_error), 32'd1);
    @(posedge clk);
    #1;
    pulse_start();
    send_byte(8'h41, 1'b0);
    bus.byte_valid = 1'b0;
    check("t3_too_many_error", 32'(bus.load_error), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t3_no_writes", 32'(wr_cnt - base_wr), 32'd0);

    // T4: full memory, addresses 0..63 in order.
    base_wr = wr_cnt;
    base_done = done_cnt;
    pulse_start();
    send_frame(64, 32'h1000_0000, -1, 1'b0, 1'b0);
    check("t4_checksum_model", 32'(frame_ck), 32'h0000_0040);
    wait_outcome(d, e);
    check("t4_done", 32'(d), 32'd1);
    check("t4_latency", 32'(cyc - start_cyc), 32'(5 * 64 + 3));
    check("t4_write_count", 32'(wr_cnt - base_wr), 32'd64);
    check("t4_last_word", last_wdata, 32'h1000_003F);
    @(negedge clk);
    check("t4_done_once", 32'(done_cnt - base_done), 32'd1);
    check("t4_hold_dropped", 32'(bus.cpu_hold), 32'd0);
    @(posedge clk);
    #1;

    // T5: gapped stream plus an ignored start pulse mid-DATA.
    base_done = done_cnt;
    pulse_start();
    send_frame(3, 32'hA5A5_0F00, -1, 1'b1, 1'b1);
    wait_outcome(d, e);
    check("t5_done", 32'(d), 32'd1);
    @(negedge clk);
    check("t5_done_once", 32'(done_cnt - base_done), 32'd1);
    check("t5_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // T6: reset after two of three words, then a fresh load.
    base_wr = wr_cnt;
    pulse_start();
    frame_ck = 8'd3;
    send_byte(8'd3, 1'b0);
    send_word(0, 32'h1111_2222, 1'b0, 1'b0);
    send_word(1, 32'h3333_4444, 1'b0, 1'b0);
    bus.byte_valid = 1'b0;
    for (int i = 0; i < 20 && wr_cnt != base_wr + 2; i++) @(negedge clk);
    check("t6_two_writes", 32'(wr_cnt - base_wr), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("t6_reset");
    rst = 1'b1;
    check("t6_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    @(posedge clk);
    #1;
    pulse_start();
    send_frame(3, 32'h0BAD_F000, -1, 1'b0, 1'b0);
    wait_outcome(d, e);
    check("t6_fresh_done", 32'(d), 32'd1);
    check("t6_fresh_no_error", 32'(bus.load_error), 32'd0);
    @(negedge clk);
    check("t6_hold_dropped", 32'(bus.cpu_hold), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
